// File: rtl/unified_mem_arbiter.sv
// Shares one busywait-style main-memory port between instruction fetch (I) and data access (D).
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               I_READ,
    input  logic [ADDR_WIDTH-1:0]              I_ADDR,
    output logic [DATA_WIDTH-1:0]              I_READDATA,
    output logic                               I_BUSYWAIT,
    input  logic                               D_READ,
    input  logic                               D_WRITE,
    input  logic [ADDR_WIDTH-1:0]              D_ADDR,
    input  logic [DATA_WIDTH-1:0]              D_WRITEDATA,
    output logic [DATA_WIDTH-1:0]              D_READDATA,
    output logic                               D_BUSYWAIT,
    output logic                               M_READ,
    output logic                               M_WRITE,
    output logic [ADDR_WIDTH-1:0]              M_ADDR,
    output logic [DATA_WIDTH-1:0]              M_WRITEDATA,
    input  logic [DATA_WIDTH-1:0]              M_READDATA,
    input  logic                               M_BUSYWAIT,
    output logic [1:0]                         DBG_STATE,
    output logic [$clog2(STARVE_LIMIT+1)-1:0]  DBG_STARVE_CNT
);

    // Handshake: a requester raises x_READ/x_WRITE with address/data and holds them while
    // x_BUSYWAIT is high; the first cycle with x_BUSYWAIT low is the response cycle
    // (x_READDATA valid), after which the request may be dropped or replaced.

    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   starve_cnt;
    logic                   i_done;
    logic                   d_done;
    logic                   lat_write;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic [DATA_WIDTH-1:0]  i_rdata;
    logic [DATA_WIDTH-1:0]  d_rdata;
    logic                   i_elig;
    logic                   d_elig;
    logic                   grant_i;
    logic                   grant_d;
    logic                   i_complete;
    logic                   d_complete;

    // x_DONE masks the held request for the response cycle so it is not served twice.
    assign i_elig = I_READ & ~i_done;
    assign d_elig = (D_READ | D_WRITE) & ~d_done;

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_elig && (!i_elig || (starve_cnt < LIMIT))) begin
                    grant_d    = 1'b1;
                    state_next = SERVE_D;
                end else if (i_elig) begin
                    grant_i    = 1'b1;
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (!M_BUSYWAIT) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        i_complete = (state == SERVE_I) && !M_BUSYWAIT;
        d_complete = (state == SERVE_D) && !M_BUSYWAIT;
        M_READ     = (state == SERVE_I) || ((state == SERVE_D) && !lat_write);
        M_WRITE    = (state == SERVE_D) && lat_write;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            starve_cnt <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state  <= state_next;
            i_done <= i_complete;
            d_done <= d_complete;
            // A store wins over a simultaneous load: D_WRITE alone selects the op.
            if (grant_d) begin
                lat_write <= D_WRITE;
                lat_addr  <= D_ADDR;
                lat_wdata <= D_WRITEDATA;
                if (i_elig && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + 1'b1;
            end
            if (grant_i) begin
                lat_write  <= 1'b0;
                lat_addr   <= I_ADDR;
                starve_cnt <= '0;
            end
            if (i_complete) i_rdata <= M_READDATA;
            if (d_complete && !lat_write) d_rdata <= M_READDATA;
        end
    end

    assign I_BUSYWAIT     = I_READ & ~i_done;
    assign D_BUSYWAIT     = (D_READ | D_WRITE) & ~d_done;
    assign I_READDATA     = i_rdata;
    assign D_READDATA     = d_rdata;
    assign M_ADDR         = lat_addr;
    assign M_WRITEDATA    = lat_wdata;
    assign DBG_STATE      = state;
    assign DBG_STARVE_CNT = starve_cnt;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: memory model with programmable wait states,
// expected memory transactions and read responses held in queues and checked by monitors.
module tb_unified_mem_arbiter;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        I_READ;
    logic [31:0] I_ADDR;
    logic [31:0] I_READDATA;
    logic        I_BUSYWAIT;
    logic        D_READ;
    logic        D_WRITE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WRITEDATA;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic        M_READ;
    logic        M_WRITE;
    logic [31:0] M_ADDR;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_BUSYWAIT;
    logic [1:0]  DBG_STATE;
    logic [2:0]  DBG_STARVE_CNT;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } m_txn_t;

    m_txn_t      m_exp_q[$];
    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          mem_wait = 0;

    unified_mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDR(I_ADDR), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDR(D_ADDR), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDR(M_ADDR), .M_WRITEDATA(M_WRITEDATA),
        .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT),
        .DBG_STATE(DBG_STATE), .DBG_STARVE_CNT(DBG_STARVE_CNT)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    initial begin
        bit in_txn;
        int wait_cnt;
        in_txn     = 1'b0;
        wait_cnt   = 0;
        M_BUSYWAIT = 1'b0;
        M_READDATA = 32'hBAD0BAD0;
        forever begin
            @(posedge CLK);
            #1;
            M_READDATA = 32'hBAD0BAD0;
            if (M_READ === 1'b1 || M_WRITE === 1'b1) begin
                if (!in_txn) begin
                    in_txn   = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
                M_BUSYWAIT = (wait_cnt < mem_wait);
                if (!M_BUSYWAIT) begin
                    in_txn = 1'b0;
                    if (M_WRITE) mem[M_ADDR] = M_WRITEDATA;
                    else M_READDATA = mem.exists(M_ADDR) ? mem[M_ADDR] : 32'hBAD0BAD0;
                end
            end else begin
                in_txn     = 1'b0;
                M_BUSYWAIT = 1'b0;
            end
        end
    end

    // ---------------- monitors ----------------
    always @(negedge CLK) begin
        if (M_READ === 1'b1 || M_WRITE === 1'b1) begin
            if (m_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_unexpected actual=addr 0x%08h required=no transaction", M_ADDR);
            end else begin
                check("mem_write", {31'd0, M_WRITE}, {31'd0, m_exp_q[0].wr});
                check("mem_read", {31'd0, M_READ}, {31'd0, !m_exp_q[0].wr});
                check("mem_addr", M_ADDR, m_exp_q[0].addr);
                if (m_exp_q[0].wr) check("mem_wdata", M_WRITEDATA, m_exp_q[0].wdata);
                if (!M_BUSYWAIT) void'(m_exp_q.pop_front());
            end
        end
    end

    always @(negedge CLK) begin
        if (I_READ === 1'b1 && I_BUSYWAIT === 1'b0) begin
            if (i_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL i_unexpected actual=0x%08h required=no response", I_READDATA);
            end else begin
                check("i_readdata", I_READDATA, i_exp_q.pop_front());
            end
        end
        if ((D_READ === 1'b1 || D_WRITE === 1'b1) && D_BUSYWAIT === 1'b0) begin
            if (d_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d_unexpected actual=0x%08h required=no response", D_READDATA);
            end else begin
                check("d_readdata", D_READDATA, d_exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic i_fetch(input logic [31:0] addr, input int exp_stall);
        int stall;
        bit done;
        stall  = 0;
        done   = 1'b0;
        I_READ = 1'b1;
        I_ADDR = addr;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge CLK);
            if (!I_BUSYWAIT) done = 1'b1;
            else stall++;
        end
        if (!done) check("i_timeout", 32'd0, 32'd1);
        check("i_stall", stall, exp_stall);
        @(posedge CLK);
        #1;
        I_READ = 1'b0;
    endtask

    task automatic d_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input int exp_stall, input bit mangle);
        int stall;
        bit done;
        stall       = 0;
        done        = 1'b0;
        D_WRITE     = wr;
        D_READ      = rd;
        D_ADDR      = addr;
        D_WRITEDATA = wdata;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge CLK);
            if (!D_BUSYWAIT) begin
                done = 1'b1;
            end else begin
                stall++;
                // After the grant edge the inputs must no longer reach the memory port.
                if (mangle && stall == 2) begin
                    D_ADDR      = 32'h0000_0999;
                    D_WRITEDATA = 32'h0BAD_0BAD;
                end
            end
        end
        if (!done) check("d_timeout", 32'd0, 32'd1);
        check("d_stall", stall, exp_stall);
        @(posedge CLK);
        #1;
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        RESET       = 1'b1;
        I_READ      = 1'b0;
        I_ADDR      = '0;
        D_READ      = 1'b0;
        D_WRITE     = 1'b0;
        D_ADDR      = '0;
        D_WRITEDATA = '0;
        mem[32'h40]  = 32'h00A00093;
        mem[32'h100] = 32'h12345678;
        mem[32'h80]  = 32'h00C00193;
        for (int k = 0; k < 5; k++) mem[32'h300 + 4 * k] = 32'h1000 + k;
        mem[32'h400] = 32'h55AA55AA;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_state", {30'd0, DBG_STATE}, {30'd0, ST_IDLE});
        check("rst_m_read", {31'd0, M_READ}, 32'd0);
        check("rst_m_write", {31'd0, M_WRITE}, 32'd0);
        check("rst_m_addr", M_ADDR, 32'd0);
        check("rst_m_wdata", M_WRITEDATA, 32'd0);
        check("rst_i_rdata", I_READDATA, 32'd0);
        check("rst_d_rdata", D_READDATA, 32'd0);
        check("rst_busy", {30'd0, I_BUSYWAIT, D_BUSYWAIT}, 32'd0);
        check("rst_starve", {29'd0, DBG_STARVE_CNT}, 32'd0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Single zero-wait fetch: two stall cycles.
        mem_wait = 0;
        m_exp_q.push_back('{wr: 1'b0, addr: 32'h40, wdata: 32'd0});
        i_exp_q.push_back(32'h00A00093);
        i_fetch(32'h40, 2);
        check("fetch_idle", {30'd0, DBG_STATE}, {30'd0, ST_IDLE});

        // Simultaneous I/D reads, 2 wait states: D first (stall 4), I after D_DONE (stall 8).
        mem[32'h40] = 32'h00B00113;
        mem_wait    = 2;
        m_exp_q.push_back('{wr: 1'b0, addr: 32'h100, wdata: 32'd0});
        m_exp_q.push_back('{wr: 1'b0, addr: 32'h40, wdata: 32'd0});
        d_exp_q.push_back(32'h12345678);
        i_exp_q.push_back(32'h00B00113);
        fork
            i_fetch(32'h40, 8);
            d_access(1'b0, 1'b1, 32'h100, 32'd0, 4, 1'b0);
        join

        // Stores with 1 wait state; D_READDATA keeps the last loaded word.
        mem_wait = 1;
        m_exp_q.push_back('{wr: 1'b1, addr: 32'h200, wdata: 32'hDEADBEEF});
        d_exp_q.push_back(32'h12345678);
        d_access(1'b1, 1'b0, 32'h200, 32'hDEADBEEF, 3, 1'b1);
        m_exp_q.push_back('{wr: 1'b1, addr: 32'h204, wdata: 32'hCAFEF00D});
        d_exp_q.push_back(32'h12345678);
        d_access(1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 3, 1'b0);
        check("hold_m_addr", M_ADDR, 32'h204);
        check("hold_m_wdata", M_WRITEDATA, 32'hCAFEF00D);
        check("hold_m_write", {31'd0, M_WRITE}, 32'd0);
        m_exp_q.push_back('{wr: 1'b0, addr: 32'h200, wdata: 32'd0});
        d_exp_q.push_back(32'hDEADBEEF);
        d_access(1'b0, 1'b1, 32'h200, 32'd0, 3, 1'b0);

        // Starvation: fetch pending at every data grant; it is withdrawn only in the
        // D_DONE slot, where it would otherwise win because data is masked there.
        mem_wait = 0;
        for (int k = 0; k < 4; k++) begin
            I_READ = 1'b1;
            I_ADDR = 32'h80;
            D_READ = 1'b1;
            D_ADDR = 32'h300 + 4 * k;
            m_exp_q.push_back('{wr: 1'b0, addr: 32'h300 + 4 * k, wdata: 32'd0});
            d_exp_q.push_back(32'h1000 + k);
            @(posedge CLK);
            #1;
            check("starve_state_d", {30'd0, DBG_STATE}, {30'd0, ST_SERVE_D});
            check("starve_cnt", {29'd0, DBG_STARVE_CNT}, k + 1);
            @(posedge CLK);
            #1;
            I_READ = 1'b0;
            @(posedge CLK);
            #1;
        end
        I_READ = 1'b1;
        D_ADDR = 32'h310;
        m_exp_q.push_back('{wr: 1'b0, addr: 32'h80, wdata: 32'd0});
        m_exp_q.push_back('{wr: 1'b0, addr: 32'h310, wdata: 32'd0});
        i_exp_q.push_back(32'h00C00193);
        d_exp_q.push_back(32'h1004);
        @(posedge CLK);
        #1;
        check("starve_state_i", {30'd0, DBG_STATE}, {30'd0, ST_SERVE_I});
        check("starve_cnt_clr", {29'd0, DBG_STARVE_CNT}, 32'd0);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        check("after_i_state_d", {30'd0, DBG_STATE}, {30'd0, ST_SERVE_D});
        check("after_i_cnt", {29'd0, DBG_STARVE_CNT}, 32'd0);
        I_READ = 1'b0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        D_READ = 1'b0;

        // Reset while a load waits on memory; the held request is re-issued afterwards.
        mem_wait = 5;
        m_exp_q.push_back('{wr: 1'b0, addr: 32'h400, wdata: 32'd0});
        d_exp_q.push_back(32'h55AA55AA);
        D_READ = 1'b1;
        D_ADDR = 32'h400;
        @(posedge CLK);
        #1;
        check("pre_rst_state", {30'd0, DBG_STATE}, {30'd0, ST_SERVE_D});
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rst_state", {30'd0, DBG_STATE}, {30'd0, ST_IDLE});
        check("mid_rst_strobes", {30'd0, M_READ, M_WRITE}, 32'd0);
        check("mid_rst_m_addr", M_ADDR, 32'd0);
        check("mid_rst_m_wdata", M_WRITEDATA, 32'd0);
        check("mid_rst_i_rdata", I_READDATA, 32'd0);
        check("mid_rst_d_rdata", D_READDATA, 32'd0);
        check("mid_rst_d_busy", {31'd0, D_BUSYWAIT}, 32'd1);
        RESET    = 1'b0;
        mem_wait = 1;
        begin
            int  stall;
            bit  done;
            stall = 0;
            done  = 1'b0;
            for (int n = 0; n < 100 && !done; n++) begin
                @(negedge CLK);
                if (!D_BUSYWAIT) done = 1'b1;
                else stall++;
            end
            if (!done) check("reissue_timeout", 32'd0, 32'd1);
            check("reissue_stall", stall, 32'd3);
        end
        @(posedge CLK);
        #1;
        D_READ = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        check("left_m_q", m_exp_q.size(), 32'd0);
        check("left_i_q", i_exp_q.size(), 32'd0);
        check("left_d_q", d_exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
